// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 set-2 key event decoder:
//   - scan-code constants for prefixes, keyboard status bytes and modifier keys
//   - decoder FSM state encoding
//   - key event record {code, ext, make, is_repeat}
//   - small classification helpers used by the decoder FSM
// No ports (package).
// -----------------------------------------------------------------------------
package ps2_pkg;

   localparam logic [7:0] SC_EXT     = 8'hE0;
   localparam logic [7:0] SC_BRK     = 8'hF0;
   localparam logic [7:0] SC_PAUSE   = 8'hE1;
   localparam logic [7:0] SC_BAT     = 8'hAA;
   localparam logic [7:0] SC_ACK     = 8'hFA;
   localparam logic [7:0] SC_RESEND  = 8'hFE;
   localparam logic [7:0] SC_ECHO    = 8'hEE;
   localparam logic [7:0] SC_NULL    = 8'h00;
   localparam logic [7:0] SC_OVERRUN = 8'hFF;
   localparam logic [7:0] SC_LSHIFT  = 8'h12;
   localparam logic [7:0] SC_RSHIFT  = 8'h59;
   localparam logic [7:0] SC_CTRL    = 8'h14;
   localparam logic [7:0] SC_ALT     = 8'h11;
   localparam logic [7:0] SC_CAPS    = 8'h58;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK,
      ST_PAUSE
   } dec_state_t;

   // "repeat" is a reserved word, hence is_repeat
   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       make;
      logic       is_repeat;
   } key_event_t;

   // Keyboard status / self-test bytes that never form a key event
   function automatic logic is_status_byte(input logic [7:0] b);
      return (b == SC_BAT) || (b == SC_ACK) || (b == SC_RESEND) ||
             (b == SC_ECHO) || (b == SC_NULL) || (b == SC_OVERRUN);
   endfunction

   // E0-prefixed shift codes are synthetic (sent around Ins/Del/arrows etc.)
   function automatic logic is_fake_shift(input logic [7:0] b);
      return (b == SC_LSHIFT) || (b == SC_RSHIFT);
   endfunction

endpackage

// File: rtl/ps2_pop_ctrl.sv
// -----------------------------------------------------------------------------
// ps2_pop_ctrl
// Pops bytes from the PS/2 receiver FIFO. A pop is taken whenever the FIFO is
// non-empty and no pop happened in the previous clock; the pop strobe is one
// clock wide and is always followed by a one-clock gap, so the FIFO's head has
// time to advance before rx_ready is sampled again.
// Ports:
//   clk, clrn    clock, asynchronous active-low reset
//   rx_data      FIFO head byte (valid while rx_ready=1)
//   rx_ready     FIFO non-empty
//   nextdata_n   active-low pop strobe to the FIFO
//   byte_data    byte latched by the last pop
//   byte_vld     1-clk strobe: byte_data holds a freshly popped byte
// -----------------------------------------------------------------------------
module ps2_pop_ctrl (
   input  logic       clk,
   input  logic       clrn,
   input  logic [7:0] rx_data,
   input  logic       rx_ready,
   output logic       nextdata_n,
   output logic [7:0] byte_data,
   output logic       byte_vld
);

   logic       pop;
   logic [7:0] data;
   logic       take;

   assign take = rx_ready & ~pop;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         pop  <= 1'b0;
         data <= 8'h00;
      end else begin
         pop <= take;
         if (take) data <= rx_data;
      end
   end

   assign nextdata_n = ~pop;
   assign byte_data  = data;
   assign byte_vld   = pop;

endmodule

// File: rtl/ps2_key_event_decoder.sv
// -----------------------------------------------------------------------------
// ps2_key_event_decoder
// Consumes raw set-2 scan-code bytes from the PS/2 receiver FIFO and turns
// prefix sequences (E0 extended, F0 break, E1 Pause) into single key events.
// Tracks the currently held key and counts its releases.
// Optional build macro: PS2_DEC_MODIFIER_EN -- adds shift/ctrl/alt/caps-lock
// tracking; when undefined the four modifier outputs are tied low.
// Ports:
//   clk, clrn     clock, asynchronous active-low reset
//   rx_data       FIFO head byte        rx_ready  FIFO non-empty
//   rx_overflow   receiver FIFO overflow (sticky err, aborts partial prefix)
//   nextdata_n    active-low 1-clk pop strobe to the FIFO
//   ev_valid      1-clk event pulse; ev_code/ev_ext/ev_make/ev_repeat hold
//                 the last event's fields until the next one
//   held_code     currently held key (00 if none), held_ext its E0 flag
//   press_count   releases of the held key (wraps at 2^CNT_W)
//   err           sticky overflow / protocol-fault flag
//   mod_shift, mod_ctrl, mod_alt, caps_lock   modifier state
// -----------------------------------------------------------------------------
module ps2_key_event_decoder
   import ps2_pkg::*;
#(
   parameter int CNT_W     = 8,
   parameter int PAUSE_LEN = 7
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic [7:0]       rx_data,
   input  logic             rx_ready,
   input  logic             rx_overflow,
   output logic             nextdata_n,
   output logic             ev_valid,
   output logic [7:0]       ev_code,
   output logic             ev_ext,
   output logic             ev_make,
   output logic             ev_repeat,
   output logic [7:0]       held_code,
   output logic             held_ext,
   output logic [CNT_W-1:0] press_count,
   output logic             err,
   output logic             mod_shift,
   output logic             mod_ctrl,
   output logic             mod_alt,
   output logic             caps_lock
);

   localparam int PC_W = (PAUSE_LEN < 2) ? 1 : $clog2(PAUSE_LEN + 1);

   logic [7:0]  byte_data;
   logic        byte_vld;

   dec_state_t  state, state_nx;
   logic [PC_W-1:0] pcnt, pcnt_nx;

   logic        fire;
   logic        hit;
   logic        proto_err;
   key_event_t  fire_ev;
   key_event_t  ev_q;
   logic        ev_valid_q;

   ps2_pop_ctrl u_pop (
      .clk        (clk),
      .clrn       (clrn),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .nextdata_n (nextdata_n),
      .byte_data  (byte_data),
      .byte_vld   (byte_vld)
   );

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state <= ST_IDLE;
         pcnt  <= '0;
      end else begin
         state <= state_nx;
         pcnt  <= pcnt_nx;
      end
   end

   // Prefix parser. An overflow in the same clock as a byte discards that byte.
   always_comb begin
      state_nx  = state;
      pcnt_nx   = pcnt;
      fire      = 1'b0;
      proto_err = 1'b0;
      fire_ev   = '0;
      hit       = 1'b0;
      if (rx_overflow) begin
         state_nx = ST_IDLE;
         pcnt_nx  = '0;
      end else if (byte_vld) begin
         case (state)
            ST_IDLE: begin
               if (byte_data == SC_EXT) begin
                  state_nx = ST_EXT;
               end else if (byte_data == SC_BRK) begin
                  state_nx = ST_BRK;
               end else if (byte_data == SC_PAUSE) begin
                  state_nx = ST_PAUSE;
                  pcnt_nx  = '0;
               end else if (!is_status_byte(byte_data)) begin
                  fire         = 1'b1;
                  fire_ev.code = byte_data;
                  fire_ev.make = 1'b1;
               end
            end
            ST_EXT: begin
               if (byte_data == SC_BRK) begin
                  state_nx = ST_EXT_BRK;
               end else if (byte_data == SC_EXT) begin
                  state_nx = ST_EXT;
               end else if (is_fake_shift(byte_data)) begin
                  state_nx = ST_IDLE;
               end else begin
                  fire         = 1'b1;
                  fire_ev.code = byte_data;
                  fire_ev.ext  = 1'b1;
                  fire_ev.make = 1'b1;
                  state_nx     = ST_IDLE;
               end
            end
            ST_BRK: begin
               if (byte_data == SC_BRK) begin
                  state_nx = ST_BRK;
               end else if (byte_data == SC_EXT) begin
                  // F0 E0 is out of order: flag it, keep the extended prefix
                  proto_err = 1'b1;
                  state_nx  = ST_EXT;
               end else begin
                  fire         = 1'b1;
                  fire_ev.code = byte_data;
                  state_nx     = ST_IDLE;
               end
            end
            ST_EXT_BRK: begin
               state_nx = ST_IDLE;
               if (!is_fake_shift(byte_data)) begin
                  fire         = 1'b1;
                  fire_ev.code = byte_data;
                  fire_ev.ext  = 1'b1;
               end
            end
            ST_PAUSE: begin
               // Pause sends E1 + PAUSE_LEN bytes and never a release
               pcnt_nx = pcnt + PC_W'(1);
               if (pcnt_nx == PC_W'(PAUSE_LEN)) begin
                  fire         = 1'b1;
                  fire_ev.code = SC_PAUSE;
                  fire_ev.make = 1'b1;
                  pcnt_nx      = '0;
                  state_nx     = ST_IDLE;
               end
            end
            default: begin
               state_nx = ST_IDLE;
               pcnt_nx  = '0;
            end
         endcase
      end
      hit               = ({fire_ev.ext, fire_ev.code} == {held_ext, held_code});
      fire_ev.is_repeat = fire_ev.make & hit;
   end

   // Event register and held-key tracking
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         ev_valid_q  <= 1'b0;
         ev_q        <= '0;
         held_code   <= 8'h00;
         held_ext    <= 1'b0;
         press_count <= '0;
         err         <= 1'b0;
      end else begin
         ev_valid_q <= fire;
         if (rx_overflow || proto_err) err <= 1'b1;
         if (fire) begin
            ev_q <= fire_ev;
            if (fire_ev.make) begin
               if (!hit) begin
                  held_code <= fire_ev.code;
                  held_ext  <= fire_ev.ext;
               end
            end else if (hit) begin
               held_code   <= 8'h00;
               held_ext    <= 1'b0;
               press_count <= press_count + CNT_W'(1);
            end
         end
      end
   end

   assign ev_valid  = ev_valid_q;
   assign ev_code   = ev_q.code;
   assign ev_ext    = ev_q.ext;
   assign ev_make   = ev_q.make;
   assign ev_repeat = ev_q.is_repeat;

`ifdef PS2_DEC_MODIFIER_EN
   logic lshift, rshift, ctrl, alt, caps;

   // Modifiers follow make/break events directly, regardless of held_code
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         lshift <= 1'b0;
         rshift <= 1'b0;
         ctrl   <= 1'b0;
         alt    <= 1'b0;
         caps   <= 1'b0;
      end else if (fire) begin
         case (fire_ev.code)
            SC_LSHIFT: lshift <= fire_ev.make;
            SC_RSHIFT: rshift <= fire_ev.make;
            SC_CTRL:   ctrl   <= fire_ev.make;
            SC_ALT:    alt    <= fire_ev.make;
            SC_CAPS:   if (fire_ev.make && !fire_ev.is_repeat) caps <= ~caps;
            default:   ;
         endcase
      end
   end

   assign mod_shift = lshift | rshift;
   assign mod_ctrl  = ctrl;
   assign mod_alt   = alt;
   assign caps_lock = caps;
`else
   assign mod_shift = 1'b0;
   assign mod_ctrl  = 1'b0;
   assign mod_alt   = 1'b0;
   assign caps_lock = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_ps2_key_event_decoder
// Bench for ps2_key_event_decoder: a queue stands in for the receiver FIFO,
// a flag-based prefix parser tracks expected events and key state, and
// table vectors, hand sequences and random byte streams drive the design.
// -----------------------------------------------------------------------------
module tb_ps2_key_event_decoder;

   localparam int CNT_W     = 8;
   localparam int PAUSE_LEN = 7;

   logic             clk = 1'b0;
   logic             clrn = 1'b0;
   logic [7:0]       rx_data = 8'h00;
   logic             rx_ready = 1'b0;
   logic             rx_overflow = 1'b0;
   logic             nextdata_n;
   logic             ev_valid;
   logic [7:0]       ev_code;
   logic             ev_ext;
   logic             ev_make;
   logic             ev_repeat;
   logic [7:0]       held_code;
   logic             held_ext;
   logic [CNT_W-1:0] press_count;
   logic             err;
   logic             mod_shift;
   logic             mod_ctrl;
   logic             mod_alt;
   logic             caps_lock;

   ps2_key_event_decoder #(.CNT_W(CNT_W), .PAUSE_LEN(PAUSE_LEN)) dut (
      .clk         (clk),
      .clrn        (clrn),
      .rx_data     (rx_data),
      .rx_ready    (rx_ready),
      .rx_overflow (rx_overflow),
      .nextdata_n  (nextdata_n),
      .ev_valid    (ev_valid),
      .ev_code     (ev_code),
      .ev_ext      (ev_ext),
      .ev_make     (ev_make),
      .ev_repeat   (ev_repeat),
      .held_code   (held_code),
      .held_ext    (held_ext),
      .press_count (press_count),
      .err         (err),
      .mod_shift   (mod_shift),
      .mod_ctrl    (mod_ctrl),
      .mod_alt     (mod_alt),
      .caps_lock   (caps_lock)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int tests = 0;
   int fails = 0;
   int obs_ev = 0;
   int obs_rep = 0;

   logic [7:0] q [$];

   // reference model state
   logic       m_pfx_ext, m_pfx_brk;
   int         m_pause;
   logic [7:0] m_held;
   logic       m_hext;
   logic [7:0] m_cnt;
   logic       m_err;
   logic [7:0] m_code;
   logic       m_xev, m_make, m_rep;
   logic       m_lsh, m_rsh, m_ctrl, m_alt, m_caps;
   logic       exp_ev;
   logic       exp_nd_low;

   typedef struct packed {
      logic [63:0] seq;   // first byte in the top byte lane
      logic [3:0]  n;
      logic [7:0]  held;
      logic        hext;
      logic [7:0]  evs;
      logic [7:0]  reps;
      logic [7:0]  rel;
   } vec_t;

   localparam int NV = 12;
   vec_t vt [NV];
   logic [7:0] pool [12];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, got, want, $time);
      end
   endtask

   task automatic model_reset();
      m_pfx_ext = 1'b0; m_pfx_brk = 1'b0; m_pause = -1;
      m_held = 8'h00; m_hext = 1'b0; m_cnt = 8'h00; m_err = 1'b0;
      m_code = 8'h00; m_xev = 1'b0; m_make = 1'b0; m_rep = 1'b0;
      m_lsh = 1'b0; m_rsh = 1'b0; m_ctrl = 1'b0; m_alt = 1'b0; m_caps = 1'b0;
      exp_ev = 1'b0; exp_nd_low = 1'b0;
   endtask

   task automatic emit(input logic mk, input logic [7:0] c, input logic x);
      logic match;
      match  = ({x, c} == {m_hext, m_held});
      exp_ev = 1'b1;
      m_code = c; m_xev = x; m_make = mk; m_rep = mk && match;
      if (mk) begin
         if (!match) begin m_held = c; m_hext = x; end
      end else if (match) begin
         m_held = 8'h00; m_hext = 1'b0; m_cnt = 8'(m_cnt + 1);
      end
`ifdef PS2_DEC_MODIFIER_EN
      if (c == 8'h12) m_lsh = mk;
      if (c == 8'h59) m_rsh = mk;
      if (c == 8'h14) m_ctrl = mk;
      if (c == 8'h11) m_alt = mk;
      if (c == 8'h58 && mk && !m_rep) m_caps = !m_caps;
`endif
      m_pfx_ext = 1'b0; m_pfx_brk = 1'b0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic fake, status;
      fake   = (b == 8'h12) || (b == 8'h59);
      status = (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
               (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
      if (m_pause >= 0) begin
         m_pause++;
         if (m_pause == PAUSE_LEN) begin
            m_pause = -1;
            emit(1'b1, 8'hE1, 1'b0);
         end
      end else if (!m_pfx_ext && !m_pfx_brk) begin
         if (b == 8'hE0) m_pfx_ext = 1'b1;
         else if (b == 8'hF0) m_pfx_brk = 1'b1;
         else if (b == 8'hE1) m_pause = 0;
         else if (!status) emit(1'b1, b, 1'b0);
      end else if (m_pfx_ext && !m_pfx_brk) begin
         if (b == 8'hF0) m_pfx_brk = 1'b1;
         else if (b == 8'hE0) m_pfx_ext = 1'b1;
         else if (fake) m_pfx_ext = 1'b0;
         else emit(1'b1, b, 1'b1);
      end else if (!m_pfx_ext && m_pfx_brk) begin
         if (b == 8'hE0) begin
            m_err = 1'b1; m_pfx_ext = 1'b1; m_pfx_brk = 1'b0;
         end else if (b != 8'hF0) emit(1'b0, b, 1'b0);
      end else begin
         if (fake) begin m_pfx_ext = 1'b0; m_pfx_brk = 1'b0; end
         else emit(1'b0, b, 1'b1);
      end
   endtask

   // One clock: FIFO + model step on the rising edge, checks on the falling edge
   task automatic cyc();
      logic nd_old, rdy_old;
      @(posedge clk);
      nd_old  = nextdata_n;
      rdy_old = rx_ready;
      exp_ev  = 1'b0;
      if (clrn) begin
         exp_nd_low = rdy_old && nd_old;
         if (rx_overflow) begin
            m_err = 1'b1; m_pfx_ext = 1'b0; m_pfx_brk = 1'b0; m_pause = -1;
         end else if (!nd_old && q.size() > 0) begin
            model_byte(q[0]);
         end
         if (!nd_old && q.size() > 0) void'(q.pop_front());
      end else begin
         exp_nd_low = 1'b0;
      end
      rx_ready <= (q.size() != 0);
      rx_data  <= (q.size() != 0) ? q[0] : 8'h00;
      @(negedge clk);
      chk("nextdata_n", 32'(nextdata_n), 32'(!exp_nd_low));
      chk("ev_valid", 32'(ev_valid), 32'(exp_ev));
      chk("ev_fields", 32'({ev_code, ev_ext, ev_make, ev_repeat}), 32'({m_code, m_xev, m_make, m_rep}));
      chk("held", 32'({held_ext, held_code}), 32'({m_hext, m_held}));
      chk("press_count", 32'(press_count), 32'(m_cnt));
      chk("err", 32'(err), 32'(m_err));
      chk("modifiers", 32'({mod_shift, mod_ctrl, mod_alt, caps_lock}),
          32'({m_lsh | m_rsh, m_ctrl, m_alt, m_caps}));
      if (ev_valid) obs_ev++;
      if (ev_valid && ev_repeat) obs_rep++;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (q.size() != 0 && k < 400) begin
         cyc();
         k++;
      end
      chk("drain_fifo_empty", 32'(q.size() == 0), 32'd1);
      repeat (3) cyc();
   endtask

   initial begin
      int e0, r0, k, pops;
      logic [7:0] c0, b;
      logic [8:0] h0;

      vt[0]  = '{64'h1CF01C0000000000, 4'd3, 8'h00, 1'b0, 8'd2, 8'd0, 8'd1};
      vt[1]  = '{64'h1C1C1CF01C000000, 4'd5, 8'h00, 1'b0, 8'd4, 8'd2, 8'd1};
      vt[2]  = '{64'hE075E0F075000000, 4'd5, 8'h00, 1'b0, 8'd2, 8'd0, 8'd1};
      vt[3]  = '{64'hE11477E1F014F077, 4'd8, 8'hE1, 1'b0, 8'd1, 8'd0, 8'd0};
      vt[4]  = '{64'hF0E1000000000000, 4'd2, 8'h00, 1'b0, 8'd1, 8'd0, 8'd1};
      vt[5]  = '{64'hE012E0F012000000, 4'd5, 8'h00, 1'b0, 8'd0, 8'd0, 8'd0};
      vt[6]  = '{64'hAAFAFEEE00FF0000, 4'd6, 8'h00, 1'b0, 8'd0, 8'd0, 8'd0};
      vt[7]  = '{64'hE01F1FE01F000000, 4'd5, 8'h1F, 1'b1, 8'd3, 8'd0, 8'd0};
      vt[8]  = '{64'hF01F000000000000, 4'd2, 8'h1F, 1'b1, 8'd1, 8'd0, 8'd0};
      vt[9]  = '{64'hE0F01F0000000000, 4'd3, 8'h00, 1'b0, 8'd1, 8'd0, 8'd1};
      vt[10] = '{64'hE0E05A0000000000, 4'd3, 8'h5A, 1'b1, 8'd1, 8'd0, 8'd0};
      vt[11] = '{64'hE0F05A0000000000, 4'd3, 8'h00, 1'b0, 8'd1, 8'd0, 8'd1};
      pool = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'h14, 8'h11, 8'h58, 8'h1C, 8'hAA, 8'h75, 8'h00};

      // reset
      model_reset();
      clrn = 1'b0;
      repeat (3) cyc();
      chk("rst_nextdata_n", 32'(nextdata_n), 32'd1);
      chk("rst_outputs", 32'({ev_valid, ev_code, ev_ext, ev_make, ev_repeat, held_code, held_ext, err}), 32'd0);
      chk("rst_press_count", 32'(press_count), 32'd0);
      clrn = 1'b1;
      repeat (2) cyc();

      // table vectors
      for (int i = 0; i < NV; i++) begin
         e0 = obs_ev; r0 = obs_rep; c0 = press_count;
         for (int j = 0; j < int'(vt[i].n); j++) q.push_back(vt[i].seq[63-8*j -: 8]);
         drain();
         chk($sformatf("vec%0d_events", i), 32'(obs_ev - e0), 32'(vt[i].evs));
         chk($sformatf("vec%0d_repeats", i), 32'(obs_rep - r0), 32'(vt[i].reps));
         chk($sformatf("vec%0d_held", i), 32'({held_ext, held_code}), 32'({vt[i].hext, vt[i].held}));
         chk($sformatf("vec%0d_releases", i), 32'(8'(press_count - c0)), 32'(vt[i].rel));
      end

      // F0 E0 protocol fault
      chk("perr_before", 32'(err), 32'd0);
      q.push_back(8'hF0); q.push_back(8'hE0); q.push_back(8'h75);
      drain();
      chk("perr_err", 32'(err), 32'd1);
      chk("perr_held", 32'({held_ext, held_code}), 32'({1'b1, 8'h75}));

      // asynchronous reset mid-sequence drops the partial prefix
      q.push_back(8'hE0); q.push_back(8'hF0);
      drain();
      #2 clrn = 1'b0;
      #1;
      chk("arst_nextdata_n", 32'(nextdata_n), 32'd1);
      chk("arst_outputs", 32'({ev_valid, ev_code, ev_ext, ev_make, held_code, held_ext, press_count, err}), 32'd0);
      model_reset();
      cyc();
      clrn = 1'b1;
      cyc();
      q.push_back(8'h1C);
      drain();
      chk("arst_prefix_lost", 32'({ev_make, ev_ext, ev_code}), 32'({1'b1, 1'b0, 8'h1C}));
      chk("arst_held", 32'({held_ext, held_code}), 32'({1'b0, 8'h1C}));

      // overflow discards a pending E0 F0 prefix
      chk("ovf_err_before", 32'(err), 32'd0);
      q.push_back(8'hE0); q.push_back(8'hF0);
      drain();
      rx_overflow = 1'b1;
      cyc();
      rx_overflow = 1'b0;
      q.push_back(8'h1C);
      drain();
      chk("ovf_err", 32'(err), 32'd1);
      chk("ovf_event", 32'({ev_make, ev_ext, ev_code, ev_repeat}), 32'({1'b1, 1'b0, 8'h1C, 1'b1}));

      // overflow in the same clock as the final byte drops the byte
      h0 = {held_ext, held_code};
      e0 = obs_ev;
      q.push_back(8'h2A);
      k = 0;
      while (nextdata_n !== 1'b0 && k < 50) begin
         cyc();
         k++;
      end
      chk("sim_pop_seen", 32'(nextdata_n), 32'd0);
      rx_overflow = 1'b1;
      cyc();
      rx_overflow = 1'b0;
      chk("sim_no_event", 32'(ev_valid), 32'd0);
      drain();
      chk("sim_dropped", 32'(obs_ev - e0), 32'd0);
      chk("sim_held", 32'({held_ext, held_code}), 32'(h0));

      // sustained rx_ready: one pop every other clock
      for (int i = 0; i < 20; i++) q.push_back(8'hAA);
      cyc();
      pops = 0;
      repeat (10) begin
         cyc();
         if (!nextdata_n) pops++;
      end
      chk("throughput_10clk", 32'(pops), 32'd5);
      drain();

`ifdef PS2_DEC_MODIFIER_EN
      b = {7'd0, caps_lock};
      q.push_back(8'h58); q.push_back(8'h58);
      drain();
      chk("caps_toggle_once", 32'(caps_lock), 32'(!b[0]));
      q.push_back(8'hF0); q.push_back(8'h58); q.push_back(8'h58); q.push_back(8'h58);
      drain();
      chk("caps_after_rerelease", 32'(caps_lock), 32'(b[0]));
`endif

      // random byte streams with occasional overflow pulses
      for (int i = 0; i < 400; i++) begin
         k = int'($urandom_range(0, 15));
         b = (k < 12) ? pool[k] : 8'($urandom);
         q.push_back(b);
         repeat ($urandom_range(1, 3)) cyc();
         if ($urandom_range(0, 39) == 0) begin
            rx_overflow = 1'b1;
            cyc();
            rx_overflow = 1'b0;
         end
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
